joybus_host_xcvr: RTL
=====================

// Module: joybus_host_xcvr
// PURPOSE
//  Parametrised Joybus host transceiver. Serialises a 1..MAX_CMD_BYTES command onto the open-drain
//  Joybus line, then captures a 0..MAX_RSP_BITS controller reply, with timeout detection.
//  Generalises the fixed ORIGIN/POLL button-driven host to arbitrary command and response lengths.
//  Sits between the command sequencer and the board-level open-drain pad (pad: out=0, oe=jb_oe).
// PARAMETERS
//  CLK_PER_US     25    clock cycles per microsecond (25 MHz system clock); must be >= 8
//  MAX_CMD_BYTES  3     command buffer depth in bytes
//  MAX_RSP_BITS   64    response shift-register width in bits
//  RX_TIMEOUT_US  100   max idle-high time before the first response falling edge
// PORTS
//  clk        in   1                  system clock
//  rst        in   1                  synchronous, active-high reset
//  cmd_valid  in   1                  command request, held until accepted
//  cmd_ready  out  1                  high in IDLE only; a transfer starts on cmd_valid&cmd_ready
//  cmd_data   in   8*MAX_CMD_BYTES    command bytes, byte 0 = [7:0] sent first, each MSB first
//  cmd_len    in   $clog2(MAX_CMD_BYTES+1)  bytes to send, 1..MAX_CMD_BYTES
//  rsp_len    in   $clog2(MAX_RSP_BITS+1)   response bits expected, 0 = no reply
//  jb_oe      out  1                  1 = pull line low, 0 = release (line pulled high externally)
//  jb_in      in   1                  raw line level, asynchronous
//  rsp_data   out  MAX_RSP_BITS       received bits, right-aligned, first bit at [rsp_len-1]
//  rsp_valid  out  1                  one-cycle pulse at transfer end
//  rsp_err    out  1                  valid with rsp_valid: 1 = timeout or short reply
//  busy       out  1                  ~cmd_ready
// BEHAVIOUR
//  Reset: state IDLE, jb_oe=0, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0.
//  cmd_data/cmd_len/rsp_len latched on handshake; later changes are ignored. cmd_len=0 is treated as 1,
//  and cmd_len>MAX_CMD_BYTES is clamped. rsp_len>MAX_RSP_BITS is clamped.
//  jb_in is passed through a 2-flop synchroniser before any use.
//  Time base: µs tick counter, free-running only while not in IDLE, zeroed on every state entry.
//  FSM:
//   IDLE    -> TX_LOW on handshake; jb_oe=1 on the cycle after acceptance.
//   TX_LOW  low 1 µs ('1' bit) or 3 µs ('0' bit) -> TX_HIGH.
//   TX_HIGH released for 3 µs ('1') or 1 µs ('0'). Next bit -> TX_LOW; after the last bit -> TX_STOP.
//   TX_STOP low 1 µs, then release. rsp_len=0 -> DONE, else -> RX_WAIT.
//   RX_WAIT wait for a synced falling edge. After RX_TIMEOUT_US µs with none -> DONE with err=1.
//   RX_BIT  sample at 2 µs after the falling edge and shift into rsp_data. Then wait for high.
//           Next falling edge -> next bit. Once rsp_len bits are taken -> RX_STOP.
//           No edge within 4 µs of the sample -> DONE with err=1 (short reply); partial bits stay visible.
//   RX_STOP wait for the controller stop bit to release the line (high); 8 µs limit (err=1) -> DONE.
//   DONE    rsp_valid=1 for one cycle -> IDLE.
//  rsp_data is cleared on handshake and holds its value until the next handshake.
//  Per bit, TX is exactly 4*CLK_PER_US cycles. Total TX = (8*cmd_len*4 + 1)*CLK_PER_US cycles.
//  jb_oe is never asserted in any RX state. Bus contention is impossible by construction.
//  Extra bits after rsp_len, during RX_STOP, are ignored (no overflow into rsp_data).
//  rst asserted mid-transfer: return to the reset state on the next clk, jb_oe drops immediately,
//  and no rsp_valid is produced.
//  cmd_valid while busy is ignored, because cmd_ready=0.
// CONFIGURATION
//  JB_RX_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchroniser.
//   Pulses of 1 cycle are rejected, and RX edge detection gets +2 cycles of latency.
//   Sample points keep the same offset from the filtered edge.
//  Not defined: the synchroniser output is used directly; a 1-cycle glitch can register as an edge.
// TESTING
//  1 reset: rst=1 for 2 clk -> jb_oe=0, cmd_ready=1, rsp_valid=0, rsp_data=0.
//  2 ORIGIN: cmd_data=8'h41, cmd_len=1, rsp_len=0 -> jb_oe lows of 75,25,75,75,75,75,75,25 cycles,
//    then a stop low of 25. rsp_valid at ~826 cycles after the handshake, with err=0.
//  3 POLL: cmd 40 03 00, rsp_len=32, bench model replies 32'hA5C3_0F81 + 2 µs stop
//    -> rsp_data[31:0]=A5C3_0F81, err=0, and jb_oe=0 throughout RX.
//  4 timeout: cmd 8'h00, rsp_len=24, no reply -> rsp_valid with err=1 after 100 µs (2500 cycles)
//    in RX_WAIT.
//  5 short reply: rsp_len=32, model sends 16 bits 16'hBEEF then stops
//    -> err=1, rsp_data[15:0]... holds the 16 bits received; rst mid-TX -> jb_oe=0 next cycle, no rsp_valid.
//  6 JB_RX_GLITCH_FILTER_EN: inject a 1-cycle low glitch in RX_WAIT -> no bit captured;
//    without the macro -> a spurious bit is captured.

Source files
------------

// File: rtl/joybus_host_xcvr_if.sv
// ----------------------------------------------------------------------------
// joybus_host_xcvr_if
//   Command/response bus between the command sequencer (master) and the
//   Joybus host transceiver (slave).
//
//   cmd_valid  m->s  command request, held until accepted
//   cmd_ready  s->m  transceiver idle; transfer starts on cmd_valid & cmd_ready
//   cmd_data   m->s  command bytes, byte 0 in [7:0] is sent first, MSB first
//   cmd_len    m->s  number of command bytes (0 -> 1, clamped to MAX_CMD_BYTES)
//   rsp_len    m->s  expected reply bits (0 = no reply, clamped to MAX_RSP_BITS)
//   rsp_data   s->m  received bits, right-aligned, first bit at [rsp_len-1]
//   rsp_valid  s->m  one-cycle pulse at end of transfer
//   rsp_err    s->m  qualifies rsp_valid: timeout or short reply
//   busy       s->m  inverse of cmd_ready
// ----------------------------------------------------------------------------
interface joybus_host_xcvr_if #(
    parameter int MAX_CMD_BYTES = 3,
    parameter int MAX_RSP_BITS  = 64
);
    localparam int CMD_LEN_W = $clog2(MAX_CMD_BYTES + 1);
    localparam int RSP_LEN_W = $clog2(MAX_RSP_BITS + 1);

    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [8*MAX_CMD_BYTES-1:0] cmd_data;
    logic [CMD_LEN_W-1:0]       cmd_len;
    logic [RSP_LEN_W-1:0]       rsp_len;
    logic [MAX_RSP_BITS-1:0]    rsp_data;
    logic                       rsp_valid;
    logic                       rsp_err;
    logic                       busy;

    modport master (
        output cmd_valid, cmd_data, cmd_len, rsp_len,
        input  cmd_ready, rsp_data, rsp_valid, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_len, rsp_len,
        output cmd_ready, rsp_data, rsp_valid, rsp_err, busy
    );
endinterface

// File: rtl/joybus_host_xcvr.sv
// ----------------------------------------------------------------------------
// joybus_host_xcvr
//   Joybus host transceiver. Serialises a 1..MAX_CMD_BYTES command onto the
//   open-drain Joybus line, then captures a 0..MAX_RSP_BITS controller reply
//   with timeout / short-reply detection. Board pad: out=0, oe=jb_oe.
//
//   Bit cell (TX and RX): 4 us. '0' = 3 us low + 1 us high,
//                                '1' = 1 us low + 3 us high. Stop = 1 us low.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   host   slave modport of joybus_host_xcvr_if (command / response bus)
//   jb_oe  out  1 = pull line low, 0 = release
//   jb_in  in   raw line level, asynchronous (2-flop synchronised)
//
// Configuration
//   JB_RX_GLITCH_FILTER_EN  when defined, a 3-sample majority filter follows
//                           the synchroniser: 1-cycle pulses are rejected and
//                           RX edges arrive 2 cycles later.
// ----------------------------------------------------------------------------
module joybus_host_xcvr #(
    parameter int CLK_PER_US    = 25,
    parameter int MAX_CMD_BYTES = 3,
    parameter int MAX_RSP_BITS  = 64,
    parameter int RX_TIMEOUT_US = 100
) (
    input  logic                     clk,
    input  logic                     rst,
    joybus_host_xcvr_if.slave        host,
    output logic                     jb_oe,
    input  logic                     jb_in
);
    localparam int CMD_LEN_W = $clog2(MAX_CMD_BYTES + 1);
    localparam int RSP_LEN_W = $clog2(MAX_RSP_BITS + 1);
    localparam int BYTE_W    = (MAX_CMD_BYTES > 1) ? $clog2(MAX_CMD_BYTES) : 1;
    localparam int CYC_W     = $clog2(CLK_PER_US);
    localparam int US_MAX    = (RX_TIMEOUT_US > 8) ? RX_TIMEOUT_US : 8;
    localparam int US_W      = $clog2(US_MAX + 1);

    // RX timing, in microseconds since entering the state
    localparam int RX_SAMPLE_US   = 2;
    localparam int RX_BIT_MAX_US  = RX_SAMPLE_US + 4;
    localparam int RX_STOP_MAX_US = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_LOW,
        S_TX_HIGH,
        S_TX_STOP,
        S_RX_WAIT,
        S_RX_BIT,
        S_RX_STOP,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [CYC_W-1:0]           cyc_q, cyc_d;
    logic [US_W-1:0]            us_q, us_d;
    logic [8*MAX_CMD_BYTES-1:0] cmd_q, cmd_d;
    logic [BYTE_W-1:0]          last_byte_q, last_byte_d;
    logic [BYTE_W-1:0]          byte_q, byte_d;
    logic [2:0]                 bitpos_q, bitpos_d;
    logic [RSP_LEN_W-1:0]       rsp_len_q, rsp_len_d;
    logic [RSP_LEN_W-1:0]       rx_cnt_q, rx_cnt_d;
    logic [MAX_RSP_BITS-1:0]    rsp_data_q, rsp_data_d;
    // RX_BIT: bit already sampled; RX_STOP: stop-bit low already seen
    logic                       phase_q, phase_d;
    logic                       err_q, err_d;
    logic                       jb_oe_q, jb_oe_d;
    logic [1:0]                 sync_q, sync_d;
    logic                       line_prev_q, line_prev_d;
    logic                       line;

    logic                       handshake;
    logic                       tick_us;
    logic                       cur_bit;
    logic                       last_bit;
    logic                       fall;
    logic                       sample_now;
    logic                       rx_last;
    logic                       restart;
    logic                       fail;
    logic                       tmr_clr;
    logic [CMD_LEN_W-1:0]       cmd_len_eff;
    logic [RSP_LEN_W-1:0]       rsp_len_eff;

    // True on the last cycle of an n-microsecond interval started at timer clear.
    function automatic logic elapsed(input logic [US_W-1:0] us, input logic tick, input int n);
        return tick && (us == US_W'(n - 1));
    endfunction

    // ------------------------------------------------------------------------
    // Line synchroniser and optional glitch filter
    // ------------------------------------------------------------------------
    assign sync_d = {sync_q[0], jb_in};

`ifdef JB_RX_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic       filt_q, filt_d;

    always_comb begin
        hist_d = {hist_q[0], sync_q[1]};
        // Majority of the current and two previous synchronised samples
        filt_d = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    assign line = filt_q;
`else
    assign line = sync_q[1];
`endif

    assign line_prev_d = line;
    assign fall        = line_prev_q && !line;

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    assign handshake  = host.cmd_valid && (state_q == S_IDLE);
    assign tick_us    = (cyc_q == CYC_W'(CLK_PER_US - 1));
    assign cur_bit    = cmd_q[{byte_q, bitpos_q}];
    assign last_bit   = (bitpos_q == 3'd0) && (byte_q == last_byte_q);
    assign sample_now = (state_q == S_RX_BIT) && !phase_q && elapsed(us_q, tick_us, RX_SAMPLE_US);
    assign rx_last    = ((rx_cnt_q + RSP_LEN_W'(1)) == rsp_len_q);

    always_comb begin
        if (host.cmd_len == '0) begin
            cmd_len_eff = CMD_LEN_W'(1);
        end else if (int'(host.cmd_len) > MAX_CMD_BYTES) begin
            cmd_len_eff = CMD_LEN_W'(MAX_CMD_BYTES);
        end else begin
            cmd_len_eff = host.cmd_len;
        end

        if (int'(host.rsp_len) > MAX_RSP_BITS) begin
            rsp_len_eff = RSP_LEN_W'(MAX_RSP_BITS);
        end else begin
            rsp_len_eff = host.rsp_len;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        fail    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (handshake) state_d = S_TX_LOW;
            end
            S_TX_LOW: begin
                if (elapsed(us_q, tick_us, cur_bit ? 1 : 3)) state_d = S_TX_HIGH;
            end
            S_TX_HIGH: begin
                if (elapsed(us_q, tick_us, cur_bit ? 3 : 1)) begin
                    state_d = last_bit ? S_TX_STOP : S_TX_LOW;
                end
            end
            S_TX_STOP: begin
                if (elapsed(us_q, tick_us, 1)) begin
                    state_d = (rsp_len_q == '0) ? S_DONE : S_RX_WAIT;
                end
            end
            S_RX_WAIT: begin
                if (fall) begin
                    state_d = S_RX_BIT;
                end else if (elapsed(us_q, tick_us, RX_TIMEOUT_US)) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end
            end
            S_RX_BIT: begin
                if (sample_now) begin
                    if (rx_last) state_d = S_RX_STOP;
                end else if (phase_q && fall) begin
                    // Next bit: stay in RX_BIT but restart the bit timer
                    restart = 1'b1;
                end else if (phase_q && elapsed(us_q, tick_us, RX_BIT_MAX_US)) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end
            end
            S_RX_STOP: begin
                // Finish only once the stop-bit low has been seen and released,
                // so trailing extra bits cannot leak into the next transfer.
                if (phase_q && line) begin
                    state_d = S_DONE;
                end else if (elapsed(us_q, tick_us, RX_STOP_MAX_US)) begin
                    state_d = S_DONE;
                    fail    = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        host.cmd_ready = (state_q == S_IDLE);
        host.busy      = (state_q != S_IDLE);
        host.rsp_valid = (state_q == S_DONE);
        host.rsp_err   = (state_q == S_DONE) && err_q;
        host.rsp_data  = rsp_data_q;
        // Registered from the next state so the pad enable is glitch-free and
        // tracks state_q cycle for cycle.
        jb_oe_d        = (state_d == S_TX_LOW) || (state_d == S_TX_STOP);
    end

    assign jb_oe = jb_oe_q;

    // ------------------------------------------------------------------------
    // Time base and datapath
    // ------------------------------------------------------------------------
    assign tmr_clr = (state_d != state_q) || restart;

    always_comb begin
        cyc_d       = cyc_q;
        us_d        = us_q;
        cmd_d       = cmd_q;
        last_byte_d = last_byte_q;
        byte_d      = byte_q;
        bitpos_d    = bitpos_q;
        rsp_len_d   = rsp_len_q;
        rx_cnt_d    = rx_cnt_q;
        rsp_data_d  = rsp_data_q;
        phase_d     = phase_q;
        err_d       = err_q;

        // Microsecond timer: runs outside IDLE, zeroed on every state entry
        if (tmr_clr || state_q == S_IDLE) begin
            cyc_d = '0;
            us_d  = '0;
        end else if (tick_us) begin
            cyc_d = '0;
            us_d  = us_q + US_W'(1);
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        if (handshake) begin
            cmd_d       = host.cmd_data;
            last_byte_d = BYTE_W'(cmd_len_eff - CMD_LEN_W'(1));
            rsp_len_d   = rsp_len_eff;
            byte_d      = '0;
            bitpos_d    = 3'd7;
            rx_cnt_d    = '0;
            rsp_data_d  = '0;
            err_d       = 1'b0;
        end

        // Advance to the next command bit at the end of each bit cell
        if (state_q == S_TX_HIGH && state_d == S_TX_LOW) begin
            if (bitpos_q == 3'd0) begin
                byte_d   = byte_q + BYTE_W'(1);
                bitpos_d = 3'd7;
            end else begin
                bitpos_d = bitpos_q - 3'd1;
            end
        end

        if (sample_now) begin
            rsp_data_d = {rsp_data_q[MAX_RSP_BITS-2:0], line};
            rx_cnt_d   = rx_cnt_q + RSP_LEN_W'(1);
        end

        if (tmr_clr) begin
            phase_d = 1'b0;
        end else if (sample_now || (state_q == S_RX_STOP && fall)) begin
            phase_d = 1'b1;
        end

        if (fail) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q       <= '0;
            us_q        <= '0;
            cmd_q       <= '0;
            last_byte_q <= '0;
            byte_q      <= '0;
            bitpos_q    <= 3'd7;
            rsp_len_q   <= '0;
            rx_cnt_q    <= '0;
            rsp_data_q  <= '0;
            phase_q     <= 1'b0;
            err_q       <= 1'b0;
            jb_oe_q     <= 1'b0;
            sync_q      <= 2'b11;
            line_prev_q <= 1'b1;
        end else begin
            cyc_q       <= cyc_d;
            us_q        <= us_d;
            cmd_q       <= cmd_d;
            last_byte_q <= last_byte_d;
            byte_q      <= byte_d;
            bitpos_q    <= bitpos_d;
            rsp_len_q   <= rsp_len_d;
            rx_cnt_q    <= rx_cnt_d;
            rsp_data_q  <= rsp_data_d;
            phase_q     <= phase_d;
            err_q       <= err_d;
            jb_oe_q     <= jb_oe_d;
            sync_q      <= sync_d;
            line_prev_q <= line_prev_d;
        end
    end

endmodule
